// File: rtl/vx_vec_dispatch_seq.sv
// Vector dispatch sequencer: splits one vector instruction into per-element
// output beats (lane 0..vl_eff-1). A scalar instruction passes through as a
// single beat. Outputs are registered, and the next instruction can load in
// the same cycle that the last beat is accepted.
module vx_vec_dispatch_seq #(
    parameter int DATAW     = 128,
    parameter int NUM_LANES = 4,
    parameter int NR_BITS   = 6,
    parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
    parameter int VL_W      = $clog2(NUM_LANES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [DATAW-1:0]   in_data,
    input  logic               in_is_vec,
    input  logic [NR_BITS-1:0] in_vd,
    input  logic [VL_W-1:0]    in_vl,
    output logic               in_ready,
    output logic               out_valid,
    output logic [DATAW-1:0]   out_data,
    output logic               out_is_vec,
    output logic [NR_BITS-1:0] out_vd,
    output logic [LANE_W-1:0]  out_vd_lane_id,
    output logic               out_vd_is_last,
    input  logic               out_ready,
    output logic               busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } state_t;

    localparam logic [VL_W:0] ONE = (VL_W + 1)'(1);

    state_t          state;
    logic [VL_W-1:0] vl_q;
    logic [VL_W-1:0] vl_eff;
    logic [VL_W:0]   lane_nxt;
    logic            lane_nxt_last;
    logic            in_fire;
    logic            out_fire;

    // Handshakes, clamped length and next-lane computation
    always_comb begin
        vl_eff        = (in_vl > VL_W'(NUM_LANES)) ? VL_W'(NUM_LANES) : in_vl;
        in_ready      = (!out_valid || out_ready) && (state == IDLE || out_vd_is_last);
        in_fire       = in_valid && in_ready;
        out_fire      = out_valid && out_ready;
        lane_nxt      = (VL_W + 1)'(out_vd_lane_id) + ONE;
        // vl_q >= 2 whenever this is used, so the subtraction cannot wrap
        lane_nxt_last = (lane_nxt == ({1'b0, vl_q} - ONE));
        busy          = (state == SEQ);
    end

    // Sequencer FSM: a new instruction takes priority, since in_ready already
    // guarantees the currently shown beat (if any) is being accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            vl_q           <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_is_vec     <= 1'b0;
            out_vd         <= '0;
            out_vd_lane_id <= '0;
            out_vd_is_last <= 1'b0;
        end else if (in_fire) begin
            vl_q           <= vl_eff;
            out_data       <= in_data;
            out_is_vec     <= in_is_vec;
            out_vd         <= in_vd;
            out_vd_lane_id <= '0;
            if (!in_is_vec) begin
                out_valid      <= 1'b1;
                out_vd_is_last <= 1'b1;
                state          <= IDLE;
            end else if (vl_eff == '0) begin
                out_valid      <= 1'b0;
                out_vd_is_last <= 1'b0;
                state          <= IDLE;
            end else if (vl_eff == VL_W'(1)) begin
                out_valid      <= 1'b1;
                out_vd_is_last <= 1'b1;
                state          <= IDLE;
            end else begin
                out_valid      <= 1'b1;
                out_vd_is_last <= 1'b0;
                state          <= SEQ;
            end
        end else if (out_fire) begin
            if (state == SEQ && !out_vd_is_last) begin
                out_vd_lane_id <= LANE_W'(lane_nxt);
                out_vd_is_last <= lane_nxt_last;
            end else begin
                out_valid <= 1'b0;
                state     <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_vx_vec_dispatch_seq.sv
// Directed bench for vx_vec_dispatch_seq: every accepted instruction pushes
// its expected beats into a queue; each cycle the shown beat is compared with
// the queue head and popped on an output handshake.
module tb_vx_vec_dispatch_seq;

    localparam int DATAW     = 128;
    localparam int NUM_LANES = 4;
    localparam int NR_BITS   = 6;
    localparam int LANE_W    = 2;
    localparam int VL_W      = 3;

    typedef struct packed {
        logic [DATAW-1:0]   data;
        logic               is_vec;
        logic [NR_BITS-1:0] vd;
        logic [LANE_W-1:0]  lane;
        logic               last;
    } beat_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic [DATAW-1:0]   in_data;
    logic               in_is_vec;
    logic [NR_BITS-1:0] in_vd;
    logic [VL_W-1:0]    in_vl;
    logic               in_ready;
    logic               out_valid;
    logic [DATAW-1:0]   out_data;
    logic               out_is_vec;
    logic [NR_BITS-1:0] out_vd;
    logic [LANE_W-1:0]  out_vd_lane_id;
    logic               out_vd_is_last;
    logic               out_ready;
    logic               busy;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    logic  accepted;

    always #5 clk = ~clk;

    vx_vec_dispatch_seq #(
        .DATAW    (DATAW),
        .NUM_LANES(NUM_LANES),
        .NR_BITS  (NR_BITS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_is_vec     (in_is_vec),
        .in_vd         (in_vd),
        .in_vl         (in_vl),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_is_vec    (out_is_vec),
        .out_vd        (out_vd),
        .out_vd_lane_id(out_vd_lane_id),
        .out_vd_is_last(out_vd_is_last),
        .out_ready     (out_ready),
        .busy          (busy)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected beats for the instruction currently on the input port
    task automatic push_model();
        beat_t       b;
        int unsigned n;
        b.data   = in_data;
        b.is_vec = in_is_vec;
        b.vd     = in_vd;
        if (!in_is_vec) begin
            b.lane = '0;
            b.last = 1'b1;
            sb.push_back(b);
        end else begin
            n = (in_vl > 3'd4) ? 4 : int'(in_vl);
            for (int unsigned i = 0; i < n; i++) begin
                b.lane = LANE_W'(i);
                b.last = (i == n - 1);
                sb.push_back(b);
            end
        end
    endtask

    // One clock: check at the falling edge, update the model, move past the rising edge
    task automatic tick(input string tag);
        beat_t cur;
        logic  exp_busy;
        logic  exp_rdy;
        @(negedge clk);
        exp_busy = 1'b0;
        exp_rdy  = 1'b1;
        if (sb.size() != 0) begin
            exp_busy = sb[0].is_vec && (sb[0].lane != '0 || !sb[0].last);
            exp_rdy  = out_ready && sb[0].last;
        end
        check({tag, ".valid"}, 256'(out_valid), 256'(sb.size() != 0));
        check({tag, ".busy"}, 256'(busy), 256'(exp_busy));
        check({tag, ".in_ready"}, 256'(in_ready), 256'(exp_rdy));
        if (out_valid && sb.size() != 0) begin
            cur = {out_data, out_is_vec, out_vd, out_vd_lane_id, out_vd_is_last};
            check({tag, ".beat"}, 256'(cur), 256'(sb[0]));
            if (out_ready) void'(sb.pop_front());
        end
        accepted = in_valid && in_ready;
        if (accepted) push_model();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input logic [DATAW-1:0] d, input logic v,
                        input logic [NR_BITS-1:0] vd, input logic [VL_W-1:0] vl,
                        input logic ordy);
        in_valid  = 1'b1;
        in_data   = d;
        in_is_vec = v;
        in_vd     = vd;
        in_vl     = vl;
        out_ready = ordy;
        accepted  = 1'b0;
        for (int k = 0; k < 20 && !accepted; k++) tick(tag);
        check({tag, ".accept"}, 256'(accepted), 256'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick(tag);
        tick(tag);
        check({tag, ".drained"}, 256'(sb.size()), 256'(0));
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        in_is_vec = 1'b0;
        in_vd     = '0;
        in_vl     = '0;
        out_ready = 1'b0;
        accepted  = 1'b0;
        reset     = 1'b1;
        #1 reset  = 1'b0;
        #1;
        check("rst.valid", 256'(out_valid), 256'(0));
        check("rst.busy", 256'(busy), 256'(0));
        check("rst.data", 256'(out_data), 256'(0));
        check("rst.vd", 256'(out_vd), 256'(0));
        check("rst.is_vec", 256'(out_is_vec), 256'(0));
        check("rst.lane", 256'(out_vd_lane_id), 256'(0));
        check("rst.last", 256'(out_vd_is_last), 256'(0));
        @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst.in_ready_after_release", 256'(in_ready), 256'(1));
        tick("idle");

        // scalar pass-through
        send("scalar", 128'hA5, 1'b0, 6'd0, 3'd0, 1'b1);
        drain("scalar");

        // full vector
        send("vec4", 128'h1234_5678, 1'b1, 6'd5, 3'd4, 1'b1);
        drain("vec4");

        // back-pressure: out_ready pattern 1,0,0,1,1
        send("bp", 128'hBEEF, 1'b1, 6'd9, 3'd3, 1'b1);
        out_ready = 1'b1; tick("bp");
        out_ready = 1'b0; tick("bp");
        out_ready = 1'b0; tick("bp");
        out_ready = 1'b1; tick("bp");
        out_ready = 1'b1; tick("bp");
        drain("bp");

        // over-length vector is clamped to NUM_LANES beats
        send("vl7", 128'h7777, 1'b1, 6'd12, 3'd7, 1'b1);
        drain("vl7");

        // zero-length vector produces no beats
        send("vl0", 128'hDEAD, 1'b1, 6'd1, 3'd0, 1'b1);
        tick("vl0");
        tick("vl0");

        // vector(vl=2) immediately followed by scalar
        send("b2b.vec", 128'hC0DE, 1'b1, 6'd3, 3'd2, 1'b1);
        send("b2b.scalar", 128'h77, 1'b0, 6'd4, 3'd0, 1'b1);
        drain("b2b");

        // reset during lane 1 of a vl=4 sequence
        send("mid", 128'hFACE, 1'b1, 6'd7, 3'd4, 1'b1);
        tick("mid");
        check("mid.lane1_shown", 256'(out_vd_lane_id), 256'(1));
        #2 reset = 1'b0;
        #1;
        check("mid.async_valid", 256'(out_valid), 256'(0));
        check("mid.async_busy", 256'(busy), 256'(0));
        check("mid.async_lane", 256'(out_vd_lane_id), 256'(0));
        sb.delete();
        @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid.in_ready_after_release", 256'(in_ready), 256'(1));
        send("mid.fresh", 128'hF00D, 1'b1, 6'd2, 3'd2, 1'b1);
        drain("mid.fresh");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule

// File: doc/vx_vec_dispatch_seq.md
VX_VEC_DISPATCH_SEQ -- requirements
Module: VX_vec_dispatch_seq

Interface
REQ-001 Parameters SHALL be:
- DATAW, 128, opaque dispatch payload width.
- NUM_LANES, 4, max vector elements per instruction (>=1).
- NR_BITS, 6, register index width.
- LANE_W, max(1, clog2(NUM_LANES)), lane-id width (derived).
- VL_W, clog2(NUM_LANES+1), vector-length width (derived).

REQ-002 Ports SHALL be:
- clk, in, 1, sole clock.
- reset, in, 1, asynchronous, active-low reset.
- in_valid, in, 1, input dispatch valid.
- in_data, in, DATAW, input payload.
- in_is_vec, in, 1, vector instruction flag.
- in_vd, in, NR_BITS, vector destination register.
- in_vl, in, VL_W, active element count.
- in_ready, out, 1, input accepted when high with in_valid.
- out_valid, out, 1, output beat valid.
- out_data, out, DATAW, payload copy.
- out_is_vec, out, 1, vector flag copy.
- out_vd, out, NR_BITS, destination register copy.
- out_vd_lane_id, out, LANE_W, element index of beat.
- out_vd_is_last, out, 1, final beat of instruction.
- out_ready, in, 1, downstream accept.
- busy, out, 1, high while a vector sequence is in progress.

REQ-003 The reset requirement SHALL be: one clock (clk); reset is asynchronous and active-low.

Function
REQ-004 An input handshake SHALL occur on in_valid && in_ready.
REQ-005 An output handshake SHALL occur on out_valid && out_ready.
REQ-006 The block SHALL be a two-state FSM: IDLE, SEQ.
REQ-007 in_ready SHALL equal (!out_valid || out_ready) && (state==IDLE || out_vd_is_last), i.e. combinational, zero-bubble reload behind the last beat.
REQ-008 Effective length SHALL be vl_eff = min(in_vl, NUM_LANES), latched on input handshake.
REQ-009 A scalar input (in_is_vec=0) SHALL produce exactly one beat next cycle.
- Beat fields: lane_id=0, is_last=1, out_is_vec=0.
- The FSM SHALL stay in or return to IDLE.
REQ-010 A vector input with vl_eff=1 SHALL produce one beat with lane_id=0, is_last=1; the FSM SHALL go to IDLE.
REQ-011 A vector input with vl_eff>=2 SHALL produce a first beat next cycle with lane_id=0, is_last=0; the FSM SHALL enter SEQ.
REQ-012 In SEQ, each output handshake SHALL increment lane_id by 1.
- is_last SHALL be high exactly when lane_id==vl_eff-1.
- The FSM SHALL return to IDLE on the handshake of the last beat.
REQ-013 A vector input with vl_eff=0 SHALL be consumed with no output beat.
- out_valid SHALL fall (or stay low) next cycle unless a prior beat is still held.
REQ-014 out_data, out_vd, and out_is_vec SHALL be constant across all beats of one instruction.
REQ-015 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-016 Latency input-to-first-beat SHALL be 1 cycle.
- Throughput SHALL be 1 beat/cycle under out_ready=1.
- Back-to-back instructions SHALL incur no bubble.
REQ-017 busy SHALL equal (state==SEQ).
REQ-018 When NUM_LANES=1, LANE_W=1 and lane_id SHALL always be 0.

Reset
REQ-019 While reset=0, asynchronously:
- state=IDLE; lane counter=0; latched vl=0.
- out_valid=0, out_data=0, out_vd=0, out_is_vec=0, out_vd_lane_id=0, out_vd_is_last=0, busy=0.
REQ-020 Reset asserted mid-sequence SHALL discard remaining beats.
- After release, the first accepted input SHALL start a fresh sequence at lane 0.
REQ-021 in_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-022 Scalar: in_is_vec=0, in_data=0xA5, out_ready=1. Required: one beat 1 cycle later, data=0xA5, lane_id=0, is_last=1, busy=0.
REQ-023 Full vector: NUM_LANES=4, in_vl=4, in_vd=5, out_ready=1. Required:
- Four consecutive beats, lane_id 0,1,2,3, vd=5.
- is_last only on lane 3.
- in_ready low until the lane-3 cycle.
REQ-024 Back-pressure: in_vl=3, out_ready toggled 1,0,0,1,1. Required:
- Beats lane 0,1,2 each held stable while stalled.
- No lane skipped or duplicated.
REQ-025 Boundaries, run as separate stimuli:
- in_vl=7 with NUM_LANES=4 -> clamped to 4 beats.
- in_vl=0 vector -> consumed, zero beats.
- Back-to-back vector(vl=2) then scalar -> beats L0, L1(last), scalar with no idle cycle.
REQ-026 Reset mid-operation: assert reset during lane 1 of a vl=4 sequence. Required:
- out_valid=0 and busy=0 immediately, without waiting for a clock edge.
- After release, a new vl=2 instruction yields lanes 0,1 only.
